// File: rtl/even_wb_sched_if.sv
// rtl/even_wb_sched_if.sv - issue/check/writeback signal bundle for the even-pipe scheduler
//
// Purpose: groups every non-clock, non-reset signal of even_wb_sched.
//   master: decode-side driver (requests, flush/stall, register checks)
//   slave : the scheduler (grants, busy flags, expected writeback)
// Signals:
//   fix_req/fix_rt, byte_req/byte_rt : issue requests and destination registers
//   stall_in, flush                  : grant suppression / reservation kill
//   chk_ra, chk_rb                   : source registers to RAW-check
//   fix_gnt, byte_gnt                : issue grants (combinational)
//   busy_ra, busy_rb                 : pending-write flags (combinational)
//   wb_valid, wb_rt, wb_unit         : expected writeback this cycle (registered)
interface even_wb_sched_if;
    logic       fix_req;
    logic [6:0] fix_rt;
    logic       byte_req;
    logic [6:0] byte_rt;
    logic       stall_in;
    logic       flush;
    logic [6:0] chk_ra;
    logic [6:0] chk_rb;
    logic       fix_gnt;
    logic       byte_gnt;
    logic       busy_ra;
    logic       busy_rb;
    logic       wb_valid;
    logic [6:0] wb_rt;
    logic       wb_unit;

    modport master (
        output fix_req, fix_rt, byte_req, byte_rt, stall_in, flush, chk_ra, chk_rb,
        input  fix_gnt, byte_gnt, busy_ra, busy_rb, wb_valid, wb_rt, wb_unit
    );

    modport slave (
        input  fix_req, fix_rt, byte_req, byte_rt, stall_in, flush, chk_ra, chk_rb,
        output fix_gnt, byte_gnt, busy_ra, busy_rb, wb_valid, wb_rt, wb_unit
    );
endinterface

// File: rtl/even_wb_sched.sv
// rtl/even_wb_sched.sv - even-pipe issue scheduler with writeback-slot reservation
//
// Purpose: grants at most one FIX or BYTE issue per cycle, only when the
// unit's writeback cycle is free, so the shared even result path never sees
// two results at once. A shift-register reservation table tracks in-flight
// destinations for RAW busy checks and predicts the writeback stream.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : even_wb_sched_if.slave (requests, checks, grants, busy, writeback)
// Parameters:
//   FIX_LAT / BYTE_LAT : grant-to-result latency of each unit (distinct, >= 1)
//   DEPTH              : reservation slots, greater than both latencies
module even_wb_sched #(
    parameter int FIX_LAT  = 2,
    parameter int BYTE_LAT = 4,
    parameter int DEPTH    = 8
) (
    input  logic           clk,
    input  logic           reset,
    even_wb_sched_if.slave bus
);

    typedef struct packed {
        logic       v;
        logic [6:0] rt;
        logic       unit;   // 0 = FIX, 1 = BYTE
    } slot_t;

    // slot_q[k] is the result expected k cycles after the current wb output.
    slot_t slot_q [DEPTH];
    logic  rr_q;            // unit holding priority: 0 = FIX, 1 = BYTE

    logic go;
    logic fix_elig;
    logic byte_elig;
    logic fix_gnt;
    logic byte_gnt;
    logic busy_a;
    logic busy_b;

    // A unit may issue only if the slot its result will occupy is free.
    assign go        = !bus.stall_in && !bus.flush && !reset;
    assign fix_elig  = go && bus.fix_req  && !slot_q[FIX_LAT].v;
    assign byte_elig = go && bus.byte_req && !slot_q[BYTE_LAT].v;

    assign fix_gnt  = fix_elig  && (!byte_elig || !rr_q);
    assign byte_gnt = byte_elig && (!fix_elig  ||  rr_q);

    assign bus.fix_gnt  = fix_gnt;
    assign bus.byte_gnt = byte_gnt;

    // Slot 0 is left out: that result is forwardable in the current cycle.
    always_comb begin
        busy_a = 1'b0;
        busy_b = 1'b0;
        for (int k = 1; k < DEPTH; k++) begin
            if (slot_q[k].v && slot_q[k].rt == bus.chk_ra) busy_a = 1'b1;
            if (slot_q[k].v && slot_q[k].rt == bus.chk_rb) busy_b = 1'b1;
        end
    end

    assign bus.busy_ra = busy_a && !reset;
    assign bus.busy_rb = busy_b && !reset;

    assign bus.wb_valid = slot_q[0].v;
    assign bus.wb_rt    = slot_q[0].rt;
    assign bus.wb_unit  = slot_q[0].unit;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k] <= '0;
            end
            rr_q <= 1'b0;
        end else if (bus.flush) begin
            // Kill every reservation; the current wb output has already been seen.
            for (int k = 0; k < DEPTH; k++) begin
                slot_q[k].v <= 1'b0;
            end
            rr_q <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                slot_q[k] <= slot_q[k + 1];
            end
            slot_q[DEPTH - 1].v <= 1'b0;
            // slot[LAT] was empty before the shift, so LAT-1 is free after it.
            if (fix_gnt) begin
                slot_q[FIX_LAT - 1] <= '{v: 1'b1, rt: bus.fix_rt, unit: 1'b0};
                rr_q                <= 1'b1;
            end else if (byte_gnt) begin
                slot_q[BYTE_LAT - 1] <= '{v: 1'b1, rt: bus.byte_rt, unit: 1'b1};
                rr_q                 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_even_wb_sched.sv
// tb/tb_even_wb_sched.sv - directed self-checking bench for even_wb_sched
module tb_even_wb_sched;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    even_wb_sched_if bus ();

    even_wb_sched #(.FIX_LAT(2), .BYTE_LAT(4), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (start of a new cycle).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Apply this cycle's inputs and let combinational outputs settle.
    task automatic drive(input logic fr, input logic [6:0] frt,
                         input logic br, input logic [6:0] brt,
                         input logic st, input logic fl);
        bus.fix_req  = fr;
        bus.fix_rt   = frt;
        bus.byte_req = br;
        bus.byte_rt  = brt;
        bus.stall_in = st;
        bus.flush    = fl;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            drive(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1;
        drive(1, 7'd1, 1, 7'd2, 0, 0);
        check("rst_fix_gnt", bus.fix_gnt, 0);
        check("rst_byte_gnt", bus.byte_gnt, 0);
        cyc();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    bit         ev  [24];
    logic [6:0] ert [24];
    logic       eu  [24];

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.chk_ra = 7'd0;
        bus.chk_rb = 7'd0;
        drive(0, 0, 0, 0, 0, 0);
        cyc();
        bus.chk_ra = 7'd5;
        drive(1, 7'd5, 1, 7'd6, 0, 0);
        check("rst_gnt_f", bus.fix_gnt, 0);
        check("rst_gnt_b", bus.byte_gnt, 0);
        check("rst_busy_a", bus.busy_ra, 0);
        cyc();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_wb_rt", bus.wb_rt, 0);
        check("rst_wb_unit", bus.wb_unit, 0);

        // 1: single FIX issue, latency 2, busy only while in slots 1..
        cyc();
        drive(1, 7'd5, 0, 0, 0, 0);
        check("t1_gnt", bus.fix_gnt, 1);
        check("t1_bgnt", bus.byte_gnt, 0);
        check("t1_busy_T", bus.busy_ra, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        check("t1_busy_T1", bus.busy_ra, 1);
        check("t1_wbv_T1", bus.wb_valid, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        check("t1_wbv_T2", bus.wb_valid, 1);
        check("t1_wbrt_T2", bus.wb_rt, 5);
        check("t1_wbu_T2", bus.wb_unit, 0);
        check("t1_busy_T2", bus.busy_ra, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        check("t1_wbv_T3", bus.wb_valid, 0);
        idle(3);

        // 2: FIX deferred when its writeback slot is taken by BYTE
        cyc();
        drive(0, 0, 1, 7'd9, 0, 0);
        check("t2_bgnt_T", bus.byte_gnt, 1);
        idle(1);
        cyc();
        drive(1, 7'd3, 0, 0, 0, 0);
        check("t2_fgnt_T2", bus.fix_gnt, 0);
        cyc();
        drive(1, 7'd3, 0, 0, 0, 0);
        check("t2_fgnt_T3", bus.fix_gnt, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        check("t2_wbv_T4", bus.wb_valid, 1);
        check("t2_wbrt_T4", bus.wb_rt, 9);
        check("t2_wbu_T4", bus.wb_unit, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        check("t2_wbv_T5", bus.wb_valid, 1);
        check("t2_wbrt_T5", bus.wb_rt, 3);
        check("t2_wbu_T5", bus.wb_unit, 0);
        idle(4);

        // 3: continuous dual requests from reset alternate FIX, BYTE, ...
        do_reset();
        for (int i = 0; i < 24; i++) begin
            ev[i]  = 1'b0;
            ert[i] = 7'd0;
            eu[i]  = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                ev[i + 2]  = 1'b1;
                ert[i + 2] = 7'(10 + i);
                eu[i + 2]  = 1'b0;
            end else begin
                ev[i + 4]  = 1'b1;
                ert[i + 4] = 7'(50 + i);
                eu[i + 4]  = 1'b1;
            end
        end
        for (int c = 0; c < 16; c++) begin
            cyc();
            if (c < 10) drive(1, 7'(10 + c), 1, 7'(50 + c), 0, 0);
            else        drive(0, 0, 0, 0, 0, 0);
            if (c < 10) begin
                check($sformatf("t3_fgnt_%0d", c), bus.fix_gnt,  (c % 2 == 0) ? 1 : 0);
                check($sformatf("t3_bgnt_%0d", c), bus.byte_gnt, (c % 2 == 1) ? 1 : 0);
            end
            check($sformatf("t3_wbv_%0d", c), bus.wb_valid, ev[c]);
            if (ev[c]) begin
                check($sformatf("t3_wbrt_%0d", c), bus.wb_rt, ert[c]);
                check($sformatf("t3_wbu_%0d", c), bus.wb_unit, eu[c]);
            end
        end
        idle(2);

        // 4: flush kills an in-flight BYTE and blocks same-cycle grants
        bus.chk_ra = 7'd12;
        cyc();
        drive(0, 0, 1, 7'd12, 0, 0);
        check("t4_bgnt_T", bus.byte_gnt, 1);
        cyc();
        drive(1, 7'd13, 1, 7'd14, 0, 1);
        check("t4_fgnt_T1", bus.fix_gnt, 0);
        check("t4_bgnt_T1", bus.byte_gnt, 0);
        check("t4_busy_T1", bus.busy_ra, 1);
        for (int k = 2; k <= 5; k++) begin
            cyc();
            drive(0, 0, 0, 0, 0, 0);
            check($sformatf("t4_busy_T%0d", k), bus.busy_ra, 0);
            check($sformatf("t4_wbv_T%0d", k), bus.wb_valid, 0);
        end

        // 5: stall blocks grants but in-flight BYTE still completes
        cyc();
        drive(0, 0, 1, 7'd20, 0, 0);
        check("t5_bgnt_T", bus.byte_gnt, 1);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            drive(1, 7'd21, 0, 0, 1, 0);
            check($sformatf("t5_fgnt_T%0d", k), bus.fix_gnt, 0);
        end
        cyc();
        drive(1, 7'd21, 0, 0, 0, 0);
        check("t5_wbv_T4", bus.wb_valid, 1);
        check("t5_wbrt_T4", bus.wb_rt, 20);
        check("t5_wbu_T4", bus.wb_unit, 1);
        check("t5_fgnt_T4", bus.fix_gnt, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        check("t5_wbv_T5", bus.wb_valid, 0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        check("t5_wbv_T6", bus.wb_valid, 1);
        check("t5_wbrt_T6", bus.wb_rt, 21);
        check("t5_wbu_T6", bus.wb_unit, 0);
        idle(4);

        // 6: reset mid-flight discards entries and restores FIX priority
        bus.chk_ra = 7'd31;
        cyc();
        drive(1, 7'd30, 0, 0, 0, 0);
        check("t6_fgnt", bus.fix_gnt, 1);
        cyc();
        drive(0, 0, 1, 7'd31, 0, 0);
        check("t6_bgnt", bus.byte_gnt, 1);
        cyc();
        reset = 1'b1;
        drive(1, 7'd32, 1, 7'd33, 0, 0);
        check("t6_rst_fgnt", bus.fix_gnt, 0);
        check("t6_rst_busy", bus.busy_ra, 0);
        check("t6_rst_wbv", bus.wb_valid, 1);
        check("t6_rst_wbrt", bus.wb_rt, 30);
        for (int k = 2; k <= 6; k++) begin
            cyc();
            reset = 1'b0;
            drive(0, 0, 0, 0, 0, 0);
            check($sformatf("t6_wbv_T%0d", k), bus.wb_valid, 0);
        end
        cyc();
        drive(1, 7'd34, 1, 7'd35, 0, 0);
        check("t6_prio_f", bus.fix_gnt, 1);
        check("t6_prio_b", bus.byte_gnt, 0);
        idle(5);

        // 7: reset with BYTE priority pending must restore FIX priority
        cyc();
        drive(1, 7'd36, 0, 0, 0, 0);
        check("t7_fgnt", bus.fix_gnt, 1);
        do_reset();
        drive(1, 7'd37, 1, 7'd38, 0, 0);
        check("t7_prio_f", bus.fix_gnt, 1);
        check("t7_prio_b", bus.byte_gnt, 0);
        idle(5);

        // 8: duplicate rt in two slots keeps busy until both drain
        bus.chk_rb = 7'd40;
        cyc();
        drive(1, 7'd40, 0, 0, 0, 0);
        check("t8_fgnt", bus.fix_gnt, 1);
        cyc();
        drive(0, 0, 1, 7'd40, 0, 0);
        check("t8_bgnt", bus.byte_gnt, 1);
        check("t8_busy_T1", bus.busy_rb, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        check("t8_busy_T2", bus.busy_rb, 1);
        check("t8_wbv_T2", bus.wb_valid, 1);
        idle(2);
        check("t8_busy_T4", bus.busy_rb, 1);
        idle(1);
        check("t8_busy_T5", bus.busy_rb, 0);
        check("t8_wbv_T5", bus.wb_valid, 1);
        check("t8_wbu_T5", bus.wb_unit, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/even_wb_sched.md
Name: even_wb_sched

Overview:
- Issue-side scheduler for the even pipe. The fixed-point (FIX) and byte (BYTE) units have different latencies but share one even result/forward path.
- Grants at most one even-pipe issue per cycle, and only when that unit's writeback cycle is free, so the two units never produce results in the same cycle.
- Keeps a reservation table of in-flight destination registers. It provides RAW busy checks to the decode stage and reports the expected writeback (valid plus rt) for cross-checking the forwarding stage.

Parameters:
- FIX_LAT, 2, cycles from FIX grant to FIX result valid (≥1).
- BYTE_LAT, 4, cycles from BYTE grant to BYTE result valid (≥1, ≠FIX_LAT).
- DEPTH, 8, number of reservation slots. Must be greater than max(FIX_LAT, BYTE_LAT).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- fix_req, input, 1, decode has a FIX-unit instruction ready to issue.
- fix_rt, input, 7, destination register of that FIX instruction.
- byte_req, input, 1, decode has a BYTE-unit instruction ready to issue.
- byte_rt, input, 7, destination register of that BYTE instruction.
- stall_in, input, 1, downstream/issue stall; suppresses grants.
- flush, input, 1, branch mispredict; kills all outstanding reservations.
- chk_ra, input, 7, source register A to check.
- chk_rb, input, 7, source register B to check.
- fix_gnt, output, 1, FIX instruction issues this cycle (combinational).
- byte_gnt, output, 1, BYTE instruction issues this cycle (combinational).
- busy_ra, output, 1, chk_ra has a pending even-pipe write (combinational).
- busy_rb, output, 1, chk_rb has a pending even-pipe write (combinational).
- wb_valid, output, 1, an even result is expected this cycle (registered).
- wb_rt, output, 7, destination of the expected result (registered).
- wb_unit, output, 1, source unit of the expected result: 0 = FIX, 1 = BYTE (registered).

Behaviour:
- State:
  - Slots 0..DEPTH-1, each holding {v, rt[7], unit}.
  - rr: 1-bit round-robin pointer naming the unit that has priority.
  - Slot k means "result appears k cycles after the current cycle's wb output".
  - wb_valid, wb_rt and wb_unit are driven directly from slot 0.
- Reset (synchronous): all slot v = 0, rt = 0, unit = 0; rr = 0 (FIX has priority). Hence wb_valid = 0, wb_rt = 0, wb_unit = 0.
  - fix_gnt, byte_gnt, busy_ra and busy_rb are 0 while reset is high, regardless of other inputs.
- Eligibility in cycle T:
  - FIX is eligible iff fix_req && !slot[FIX_LAT].v.
  - BYTE is eligible iff byte_req && !slot[BYTE_LAT].v.
  - Both require !stall_in && !flush && !reset.
- Arbitration (at most one grant per cycle):
  - Only one unit eligible: grant it.
  - Both eligible: grant the unit named by rr.
  - After any grant, rr becomes the other unit. With no grant, rr holds.
- Per-edge update, normal case:
  - slot[k] <= slot[k+1] for k = 0..DEPTH-2.
  - slot[DEPTH-1].v <= 0.
  - On a grant, slot[LAT-1] <= {1, rt, unit}. Because slot[LAT] was empty before the shift, this write never collides with a shifted entry.
- Latency: a grant in cycle T gives wb_valid = 1 with the granted rt in cycle T+LAT exactly.
  - Example: FIX granted at T gives wb_valid at T+2; BYTE granted at T gives wb_valid at T+4.
- Busy check:
  - busy_ra = OR over k in 1..DEPTH-1 of (slot[k].v && slot[k].rt == chk_ra). busy_rb is the same for chk_rb.
  - Slot 0 is excluded because its result is forwardable this cycle.
  - A same-cycle grant is not included.
- flush:
  - Next edge clears v in every slot (no shift survives) and sets rr = 0.
  - Grants are 0 in the flush cycle.
  - wb_valid for the current cycle is unaffected (already registered).
- stall_in: grants are 0, but the table still shifts. Units are not stallable, so in-flight results still complete.
- Simultaneous stall_in and flush: flush behaviour applies.
- Reset mid-operation: all in-flight entries are discarded at the reset edge. No wb_valid pulse appears afterwards until a new grant.
- Duplicate rt in two slots is legal. busy stays high until both slots drain.
- rt = 0 is an ordinary register with no special case.

Test Plan:
1. After reset, fix_req=1, fix_rt=7'd5 for 1 cycle at T → fix_gnt=1 at T; wb_valid=1, wb_rt=5, wb_unit=0 at T+2 only; busy_ra (chk_ra=5) high in T+1 only.
2. BYTE granted at T (byte_rt=9), then fix_req at T+2 (fix_rt=3) → FIX writeback would land at T+4, colliding with BYTE; fix_gnt=0 at T+2 and fix_gnt=1 at T+3; wb at T+4 = {9, BYTE} and at T+5 = {3, FIX}.
3. fix_req=byte_req=1 continuously from reset → grants alternate FIX, BYTE, FIX, … (FIX first), never both in one cycle; wb_valid never shows two results in one cycle; all grants eventually appear on wb in order of writeback slot.
4. BYTE granted at T (rt=12), flush=1 at T+1 → no wb_valid at T+4; busy_ra (chk_ra=12) is 0 from T+2; requests during T+1 are not granted.
5. stall_in=1 at T+1..T+3 with fix_req held, after a BYTE grant at T (rt=20) → no grants T+1..T+3; wb {20, BYTE} still appears at T+4; FIX is granted at T+4 and writes back at T+6.
6. reset asserted for 1 cycle at T+1 after grants at T-1 (FIX) and T (BYTE) → wb_valid=0 from T+2 onward; rr restored, so the next simultaneous request grants FIX.
